stream_cipher_solver: RTL and testbench

STREAM_CIPHER_SOLVER -- requirements
Module: stream_cipher_solver

---
 rtl/stream_cipher_solver.sv | 134 +++++++++++++
 tb/tb_stream_cipher_solver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_cipher_solver.sv
// Block stream cipher: parity-tagged XOR with an LFSR keystream.
// Encrypts or decrypts one character per cycle, NCHAR characters per block.
module stream_cipher_solver #(
  parameter int CHAR_W = 6,
  parameter int NCHAR  = 10
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Start,
  input  logic                       Mode,
  input  logic [15:0]                Key,
  input  logic [NCHAR*CHAR_W-1:0]    Raw_In,
  input  logic [NCHAR*(CHAR_W+1)-1:0] Enc_In,
  output logic [NCHAR*(CHAR_W+1)-1:0] Enc_Out,
  output logic [NCHAR*CHAR_W-1:0]    Raw_Out,
  output logic [NCHAR-1:0]           Err_Mask,
  output logic                       Busy,
  output logic                       Done
);

  localparam int SYM_W = CHAR_W + 1;
  localparam int RAW_W = NCHAR * CHAR_W;
  localparam int ENC_W = NCHAR * SYM_W;
  localparam int IDX_W = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHAR - 1);
  localparam logic [15:0] SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT state, nextState;

  logic [IDX_W-1:0]  idx;
  logic [15:0]       lfsr;
  logic [15:0]       lfsrNext;
  logic              modeLat;
  logic [RAW_W-1:0]  rawLat;
  logic [ENC_W-1:0]  encLat;
  logic [ENC_W-1:0]  encAcc, encAccNext;
  logic [RAW_W-1:0]  rawAcc, rawAccNext;
  logic [NCHAR-1:0]  errAcc, errAccNext;

  logic [CHAR_W-1:0] ks;
  logic [CHAR_W-1:0] rawCh;
  logic [SYM_W-1:0]  symCh;
  logic [SYM_W-1:0]  encSym;
  logic [CHAR_W-1:0] decCh;
  logic              decErr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (Start) nextState = RUN;
      RUN:     if (idx == LAST) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN) || (state == DONE);
    Done = (state == DONE);
  end

  // Both directions are computed every RUN cycle; modeLat picks what lands.
  assign ks       = lfsr[CHAR_W-1:0];
  assign rawCh    = rawLat[idx*CHAR_W +: CHAR_W];
  assign symCh    = encLat[idx*SYM_W +: SYM_W];
  assign encSym   = {^rawCh, rawCh ^ ks};
  assign decCh    = symCh[CHAR_W-1:0] ^ ks;
  assign decErr   = (^decCh) != symCh[CHAR_W];
  assign lfsrNext = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_comb begin
    encAccNext = encAcc;
    rawAccNext = rawAcc;
    errAccNext = errAcc;
    encAccNext[idx*SYM_W +: SYM_W]   = encSym;
    rawAccNext[idx*CHAR_W +: CHAR_W] = decCh;
    errAccNext[idx]                  = decErr;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx      <= '0;
      lfsr     <= SEED;
      modeLat  <= 1'b0;
      rawLat   <= '0;
      encLat   <= '0;
      encAcc   <= '0;
      rawAcc   <= '0;
      errAcc   <= '0;
      Enc_Out  <= '0;
      Raw_Out  <= '0;
      Err_Mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            modeLat <= Mode;
            rawLat  <= Raw_In;
            encLat  <= Enc_In;
            idx     <= '0;
            lfsr    <= (Key == 16'h0) ? SEED : Key;
          end
        end
        RUN: begin
          lfsr   <= lfsrNext;
          encAcc <= encAccNext;
          rawAcc <= rawAccNext;
          errAcc <= errAccNext;
          if (idx == LAST) begin
            idx <= '0;
            if (modeLat) begin
              Raw_Out  <= rawAccNext;
              Err_Mask <= errAccNext;
            end else begin
              Enc_Out  <= encAccNext;
              Err_Mask <= '0;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_cipher_solver.sv
// Randomized directed bench for stream_cipher_solver with a
// behavioural cipher model; covers default and 8x4 geometries.
module tb_stream_cipher_solver;

  localparam int CW  = 6;
  localparam int NC  = 10;
  localparam int EW  = NC * (CW + 1);
  localparam int RW  = NC * CW;
  localparam int CW8 = 8;
  localparam int NC8 = 4;
  localparam int EW8 = NC8 * (CW8 + 1);
  localparam int RW8 = NC8 * CW8;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst_n;
  logic          Start, Mode;
  logic [15:0]   Key;
  logic [RW-1:0] Raw_In;
  logic [EW-1:0] Enc_In;
  logic [EW-1:0] Enc_Out;
  logic [RW-1:0] Raw_Out;
  logic [NC-1:0] Err_Mask;
  logic          Busy, Done;

  logic           s8Start, s8Mode;
  logic [15:0]    s8Key;
  logic [RW8-1:0] s8RawIn;
  logic [EW8-1:0] s8EncIn;
  logic [EW8-1:0] s8EncOut;
  logic [RW8-1:0] s8RawOut;
  logic [NC8-1:0] s8Err;
  logic           s8Busy, s8Done;

  stream_cipher_solver #(.CHAR_W(CW), .NCHAR(NC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mode(Mode), .Key(Key),
    .Raw_In(Raw_In), .Enc_In(Enc_In), .Enc_Out(Enc_Out),
    .Raw_Out(Raw_Out), .Err_Mask(Err_Mask), .Busy(Busy), .Done(Done)
  );

  stream_cipher_solver #(.CHAR_W(CW8), .NCHAR(NC8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(s8Start), .Mode(s8Mode),
    .Key(s8Key), .Raw_In(s8RawIn), .Enc_In(s8EncIn),
    .Enc_Out(s8EncOut), .Raw_Out(s8RawOut), .Err_Mask(s8Err),
    .Busy(s8Busy), .Done(s8Done)
  );

  int nCmp = 0;
  int nFail = 0;

  logic [EW-1:0] expEnc;
  logic [RW-1:0] expRaw;
  logic [NC-1:0] expErr;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] stepL(input logic [15:0] l);
    logic [15:0] fb;
    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (fb << 15);
  endfunction

  function automatic logic [127:0] modelEnc(input int cw, input int nc,
      input logic [15:0] key, input logic [127:0] raw);
    logic [127:0] res, ch, mask, sym;
    logic [15:0] l;
    res  = '0;
    mask = (128'd1 << cw) - 128'd1;
    l    = (key == 16'd0) ? 16'hACE1 : key;
    for (int i = 0; i < nc; i++) begin
      ch  = (raw >> (i * cw)) & mask;
      sym = ({127'd0, ^ch} << cw) | (ch ^ (128'(l) & mask));
      res = res | (sym << (i * (cw + 1)));
      l   = stepL(l);
    end
    return res;
  endfunction

  task automatic modelDec(input int cw, input int nc, input logic [15:0] key,
      input logic [127:0] enc, output logic [127:0] raw,
      output logic [127:0] err);
    logic [127:0] mask, sym, ch;
    logic [15:0] l;
    raw  = '0;
    err  = '0;
    mask = (128'd1 << cw) - 128'd1;
    l    = (key == 16'd0) ? 16'hACE1 : key;
    for (int i = 0; i < nc; i++) begin
      sym = (enc >> (i * (cw + 1))) & ((mask << 1) | 128'd1);
      ch  = (sym & mask) ^ (128'(l) & mask);
      raw = raw | (ch << (i * cw));
      if ((^ch) != sym[cw]) err = err | (128'd1 << i);
      l = stepL(l);
    end
  endtask

  task automatic scramble();
    Mode   = 1'($urandom);
    Key    = 16'($urandom);
    Raw_In = RW'({$urandom(), $urandom()});
    Enc_In = EW'({$urandom(), $urandom(), $urandom()});
  endtask

  // One block on the default instance, cycle-accurate Busy/Done checks.
  task automatic runBlock(input logic m, input logic [15:0] k,
      input logic [RW-1:0] r, input logic [EW-1:0] e, input int reStartAt);
    logic [127:0] nEnc, nRaw, nErr;
    @(negedge Clk);
    Mode = m; Key = k; Raw_In = r; Enc_In = e; Start = 1'b1;
    nEnc = modelEnc(CW, NC, k, 128'(r));
    modelDec(CW, NC, k, 128'(e), nRaw, nErr);
    @(posedge Clk);
    #1 Start = 1'b0;
    scramble();
    for (int kk = 0; kk <= NC + 2; kk++) begin
      @(negedge Clk);
      if (kk == NC - 1) begin
        check("hold_enc", 128'(Enc_Out), 128'(expEnc));
        check("hold_raw", 128'(Raw_Out), 128'(expRaw));
        check("hold_err", 128'(Err_Mask), 128'(expErr));
      end
      if (kk == NC) begin
        if (m) begin
          expRaw = nRaw[RW-1:0];
          expErr = nErr[NC-1:0];
        end else begin
          expEnc = nEnc[EW-1:0];
          expErr = '0;
        end
        check("enc_out", 128'(Enc_Out), 128'(expEnc));
        check("raw_out", 128'(Raw_Out), 128'(expRaw));
        check("err_mask", 128'(Err_Mask), 128'(expErr));
      end
      check("busy", 128'(Busy), 128'(kk <= NC));
      check("done", 128'(Done), 128'(kk == NC));
      Start = (kk == reStartAt - 1);
    end
  endtask

  task automatic run8(input logic m, input logic [15:0] k,
      input logic [RW8-1:0] r, input logic [EW8-1:0] e);
    bit seen;
    @(negedge Clk);
    s8Mode = m; s8Key = k; s8RawIn = r; s8EncIn = e; s8Start = 1'b1;
    @(posedge Clk);
    #1 s8Start = 1'b0;
    s8RawIn = '1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      seen = s8Done;
    end
    check("d8_done_seen", 128'(seen), 128'd1);
  endtask

  logic [15:0]    key;
  logic [RW-1:0]  raw;
  logic [EW-1:0]  cipher;
  logic [EW-1:0]  ref0;
  logic [RW8-1:0] raw8;
  logic [127:0]   c8;

  initial begin
    Rst_n = 1'b1;
    Start = 1'b0; Mode = 1'b0; Key = '0; Raw_In = '0; Enc_In = '0;
    s8Start = 1'b0; s8Mode = 1'b0; s8Key = '0; s8RawIn = '0; s8EncIn = '0;
    expEnc = '0; expRaw = '0; expErr = '0;
    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 128'(Busy), 128'd0);
    check("rst_done", 128'(Done), 128'd0);
    check("rst_enc", 128'(Enc_Out), 128'd0);
    check("rst_raw", 128'(Raw_Out), 128'd0);
    check("rst_err", 128'(Err_Mask), 128'd0);
    #1 Rst_n = 1'b1;

    // Known vectors with Key=1
    runBlock(1'b0, 16'h0001, '0, '0, -1);
    check("kv_enc", 128'(Enc_Out), 128'h1);
    check("kv_err0", 128'(Err_Mask), 128'd0);
    runBlock(1'b1, 16'h0001, '1, EW'(1), -1);
    check("kv_dec", 128'(Raw_Out), 128'd0);
    check("kv_err1", 128'(Err_Mask), 128'd0);

    // Random round trips
    for (int t = 0; t < 4; t++) begin
      key = 16'($urandom);
      raw = RW'({$urandom(), $urandom()});
      runBlock(1'b0, key, raw, EW'($urandom), -1);
      cipher = EW'(modelEnc(CW, NC, key, 128'(raw)));
      runBlock(1'b1, key, RW'($urandom), cipher, -1);
      check("rt_raw", 128'(Raw_Out), 128'(raw));
      check("rt_err", 128'(Err_Mask), 128'd0);
    end

    // Parity bit of symbol 0 flipped
    key = 16'($urandom);
    raw = RW'({$urandom(), $urandom()});
    cipher = EW'(modelEnc(CW, NC, key, 128'(raw)));
    cipher[6] = ~cipher[6];
    runBlock(1'b1, key, '0, cipher, -1);
    check("par_err", 128'(Err_Mask), 128'h001);
    check("par_raw", 128'(Raw_Out), 128'(raw));

    // Key 0 equals ACE1; restart at T+3 ignored
    raw = RW'({$urandom(), $urandom()});
    runBlock(1'b0, 16'h0000, raw, '0, 3);
    ref0 = Enc_Out;
    runBlock(1'b0, 16'hACE1, raw, '1, -1);
    check("key0_eq", 128'(Enc_Out), 128'(ref0));

    // Reset mid-block
    @(negedge Clk);
    Mode = 1'b0; Key = 16'h1234; Raw_In = '1; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk);
      #1 check("abort_nodone", 128'(Done), 128'd0);
    end
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("ab_busy", 128'(Busy), 128'd0);
    check("ab_done", 128'(Done), 128'd0);
    check("ab_enc", 128'(Enc_Out), 128'd0);
    check("ab_raw", 128'(Raw_Out), 128'd0);
    check("ab_err", 128'(Err_Mask), 128'd0);
    expEnc = '0; expRaw = '0; expErr = '0;
    repeat (2) begin
      @(negedge Clk);
      check("ab_hold_done", 128'(Done), 128'd0);
    end
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    key = 16'($urandom);
    raw = RW'({$urandom(), $urandom()});
    runBlock(1'b0, key, raw, '0, -1);
    cipher = EW'(modelEnc(CW, NC, key, 128'(raw)));
    runBlock(1'b1, key, '0, cipher, -1);
    check("ab_rt", 128'(Raw_Out), 128'(raw));

    // 8-bit, 4-character geometry
    for (int t = 0; t < 3; t++) begin
      key  = 16'($urandom);
      raw8 = RW8'($urandom);
      c8   = modelEnc(CW8, NC8, key, 128'(raw8));
      run8(1'b0, key, raw8, '0);
      check("d8_enc", 128'(s8EncOut), c8 & ((128'd1 << EW8) - 1));
      check("d8_err0", 128'(s8Err), 128'd0);
      run8(1'b1, key, '0, EW8'(c8));
      check("d8_raw", 128'(s8RawOut), 128'(raw8));
      check("d8_err1", 128'(s8Err), 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
